receiver_core: RTL and testbench
================================

Name: receiver_core

Overview:
- Receive-side counterpart of the sender path: samples the 8-bit ADC stream carrying the sender's line waveform and recovers the transmitted bytes.
- Line format: idle high, 1 start bit (low), 8 data bits LSB first, 1 stop bit (high). Each bit lasts SAMPLES_PER_BIT clocks, so a 10-bit frame at the default is 720 cycles.
- Output: recovered byte on receiver_da, a one-cycle frame strobe, and error reporting. Sits between the ADC front end and the downstream DAC/consumer, gated by receiver_sync_in.

Parameters:
SAMPLES_PER_BIT, 72, clocks per bit; must be even and >= 8
THRESHOLD, 8'h80, ADC code at or above which the line reads as 1
DATA_BITS, 8, payload bits per frame; fixed 8 in this revision

Ports:
clock  in  1  system clock, the only clock
resetN  in  1  asynchronous, active-low reset
receiver_sync_in  in  1  receive enable; low forces IDLE
receiver_sync_out  out  1  one-cycle strobe: new valid byte on receiver_da
receiver_ad  in  8  ADC sample, one per clock
receiver_da  out  8  last correctly framed byte; held between frames
frame_err  out  1  one-cycle strobe: stop bit read low
err_count  out  8  saturating count of framing errors

Behaviour:
- Reset (resetN low, async): state IDLE, receiver_da=0, receiver_sync_out=0, frame_err=0, err_count=0, all counters 0, ad_q=0.
- Input is registered once into ad_q. Line bit lvl = (ad_q >= THRESHOLD), unsigned compare.
- Timing reference: t0 = first cycle in IDLE where lvl=0 and the previous lvl=1. Define C = SAMPLES_PER_BIT/2.
- Bit k (k=0 start, 1..8 data, 9 stop) is sampled at offsets k*SPB+C-1, +C, +C+1 from t0. Its value is the majority of those 3 samples, decided at offset k*SPB+C+1.
- States:
  - IDLE: wait for a falling edge. Transition to START at t0.
  - START: if the start-bit majority is 1 (false start), go to IDLE, with no strobe and no error. Otherwise go to DATA.
  - DATA: shift each majority into the shift register LSB first. After bit 8 go to STOP.
  - STOP: majority 1 → receiver_da <= shift register and receiver_sync_out=1 for one cycle, then IDLE. Majority 0 → frame_err=1 for one cycle, err_count+1 (saturates at 255), receiver_da unchanged, then WAIT_HIGH.
  - WAIT_HIGH: stay until lvl=1, then IDLE. This prevents a break condition from being re-decoded as start bits.
- Latency: strobe and receiver_da update are registered at offset 9*SPB+C+2 from t0, i.e. 686 at the default.
- A new frame may start the first IDLE cycle after STOP. Back-to-back frames with no idle gap must decode: the next start edge comes at offset 10*SPB, after STOP exits.
- receiver_sync_in low:
  - Synchronous abort to IDLE in the next cycle; any partial byte is discarded.
  - No strobe and no error are generated.
  - receiver_da and err_count are held.
- receiver_sync_in high with the line already low: no edge has been seen, so the block waits in IDLE for a high followed by low.
- resetN asserted mid-frame: immediate return to reset values.
- receiver_sync_out and frame_err are never asserted together.

Decomposition:
- Package receiver_pkg holds:
  - the state enum {IDLE, START, DATA, STOP, WAIT_HIGH}
  - default constants SAMPLES_PER_BIT_DEF=72, THRESHOLD_DEF=8'h80
  - a helper for majority-of-3.
- One sub-module, receiver_bit_sampler, contains the ad_q register, threshold compare, edge detect, and 3-tap majority vote. It takes SPB-relative sample enables from the core.
- The core keeps the FSM, the bit/sample counters, the shift register and the error counter.

Test Plan:
1. Reset, then sync_in=1, idle line 8'hF0, then one frame of byte 8'h20 with low=8'h10 / high=8'hF0 → a single receiver_sync_out pulse 686 cycles after the start edge, receiver_da=8'h20, frame_err never high.
2. Back-to-back frames for bytes 8'h20..8'h2F, 720 cycles each with no gap → 16 strobes spaced exactly 720 cycles apart, receiver_da sequence 8'h20..8'h2F, err_count=0.
3. Glitch low for 5 cycles on an idle line, then high → no strobe, no error, state back in IDLE; a following valid 8'hA5 frame decodes to 8'hA5.
4. Frame 8'h3C with the stop bit forced low, then line high → frame_err pulse, err_count=1, receiver_da keeps its previous value. Repeat 300 times → err_count saturates at 8'hFF.
5. Single-sample spikes (one cycle inverted at the centre of each data bit) on byte 8'h55 → majority vote rejects them, receiver_da=8'h55.
6. Drop sync_in at data bit 4 of byte 8'h77, then raise it again → no strobe, receiver_da unchanged; the next full frame 8'h11 decodes correctly. Assert resetN low mid-frame → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/receiver_pkg.sv
// Shared types and constants for the line receiver.
// State enum, default timing constants and the 3-tap vote helper.
package receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int         SAMPLES_PER_BIT_DEF = 72;
  localparam logic [7:0] THRESHOLD_DEF       = 8'h80;
  localparam int         DATA_BITS_DEF       = 8;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/receiver_bit_sampler.sv
// Registers the ADC code, slices it to a line level, flags falling
// edges and votes three consecutive samples around the bit centre.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   ad_i                  raw ADC sample
//   tap0_en_i, tap1_en_i  capture the first / second vote sample
//   lvl_o                 current line level (ad_q >= THRESHOLD)
//   fall_o                level went 1 -> 0 this cycle
//   maj_o                 majority of tap0, tap1 and current level
module receiver_bit_sampler
  import receiver_pkg::*;
#(
  parameter logic [7:0] THRESHOLD = THRESHOLD_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] ad_i,
  input  logic       tap0_en_i,
  input  logic       tap1_en_i,
  output logic       lvl_o,
  output logic       fall_o,
  output logic       maj_o
);

  logic [7:0] ad_q;
  logic       lvl_prev_q;
  logic       tap0_q;
  logic       tap1_q;

  assign lvl_o = (ad_q >= THRESHOLD);

  // Previous level resets low so reset release never looks like an edge.
  assign fall_o = lvl_prev_q & ~lvl_o;

  // Third vote sample is the live level, so the vote lands on that cycle.
  assign maj_o = maj3(tap0_q, tap1_q, lvl_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ad_q       <= '0;
      lvl_prev_q <= 1'b0;
      tap0_q     <= 1'b0;
      tap1_q     <= 1'b0;
    end else begin
      ad_q       <= ad_i;
      lvl_prev_q <= lvl_o;
      if (tap0_en_i) tap0_q <= lvl_o;
      if (tap1_en_i) tap1_q <= lvl_o;
    end
  end

endmodule

// File: rtl/receiver_core.sv
// Recovers 8N1 bytes from a sampled ADC line waveform.
// Ports:
//   clock, resetN        clock, async active-low reset
//   receiver_sync_in     receive enable, low aborts to IDLE
//   receiver_ad          ADC sample, one per clock
//   receiver_sync_out    one-cycle strobe: new byte on receiver_da
//   receiver_da          last correctly framed byte
//   frame_err            one-cycle strobe: stop bit read low
//   err_count            saturating framing error count
module receiver_core
  import receiver_pkg::*;
#(
  parameter int         SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
  parameter logic [7:0] THRESHOLD       = THRESHOLD_DEF,
  parameter int         DATA_BITS       = DATA_BITS_DEF
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       receiver_sync_in,
  input  logic [7:0] receiver_ad,
  output logic       receiver_sync_out,
  output logic [7:0] receiver_da,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int PW   = $clog2(SAMPLES_PER_BIT);
  localparam int HALF = SAMPLES_PER_BIT / 2;

  localparam logic [PW-1:0] PH_TAP0 = PW'(HALF - 1);
  localparam logic [PW-1:0] PH_TAP1 = PW'(HALF);
  localparam logic [PW-1:0] PH_DEC  = PW'(HALF + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SAMPLES_PER_BIT - 1);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [3:0]    LAST_DB = 4'(DATA_BITS);

  rx_state_e       state_q;
  logic [PW-1:0]   phase_q;
  logic [3:0]      bit_q;
  logic [7:0]      sh_q;
  logic [7:0]      da_q;
  logic            sync_out_q;
  logic            ferr_q;
  logic [7:0]      err_q;

  logic            in_frame;
  logic            tap0_en;
  logic            tap1_en;
  logic            dec;
  logic            lvl;
  logic            fall;
  logic            maj;

  assign in_frame = (state_q == START) ||
                    (state_q == DATA)  ||
                    (state_q == STOP);

  assign tap0_en = in_frame && (phase_q == PH_TAP0);
  assign tap1_en = in_frame && (phase_q == PH_TAP1);
  assign dec     = in_frame && (phase_q == PH_DEC);

  receiver_bit_sampler #(
    .THRESHOLD (THRESHOLD)
  ) u_sampler (
    .clk_i     (clock),
    .rst_ni    (resetN),
    .ad_i      (receiver_ad),
    .tap0_en_i (tap0_en),
    .tap1_en_i (tap1_en),
    .lvl_o     (lvl),
    .fall_o    (fall),
    .maj_o     (maj)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      da_q       <= '0;
      sync_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      sync_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      if (!receiver_sync_in) begin
        state_q <= IDLE;
        phase_q <= '0;
        bit_q   <= '0;
      end else begin
        // Free-running bit timer, re-armed in IDLE so that the
        // cycle after the start edge is phase 1 of bit 0.
        if (phase_q == PH_LAST) begin
          phase_q <= '0;
          bit_q   <= bit_q + 4'd1;
        end else begin
          phase_q <= phase_q + 1'b1;
        end
        unique case (state_q)
          IDLE: begin
            phase_q <= PH_ONE;
            bit_q   <= '0;
            if (fall) state_q <= START;
          end
          START: begin
            if (dec) begin
              if (maj) state_q <= IDLE;
              else     state_q <= DATA;
            end
          end
          DATA: begin
            if (dec) begin
              sh_q <= {maj, sh_q[7:1]};
              if (bit_q == LAST_DB) state_q <= STOP;
            end
          end
          STOP: begin
            if (dec) begin
              if (maj) begin
                da_q       <= sh_q;
                sync_out_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                ferr_q <= 1'b1;
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                // A held-low line must not re-trigger start bits.
                state_q <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            if (lvl) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign receiver_sync_out = sync_out_q;
  assign receiver_da       = da_q;
  assign frame_err         = ferr_q;
  assign err_count         = err_q;

endmodule

// File: tb/tb_receiver_core.sv
// Bench for receiver_core: frame driver, event scoreboard,
// per-cycle compare and a short-bit instance for saturation.
module tb_receiver_core;
  import receiver_pkg::*;

  localparam int SPB = 72;
  localparam int C   = SPB / 2;
  // Drive of start-bit low to visible strobe: 1 input register
  // cycle plus 9*SPB+C+2 from the start edge.
  localparam int LAT = 9 * SPB + C + 3;
  localparam logic [7:0] HI = 8'hF0;
  localparam logic [7:0] LO = 8'h10;
  localparam int SPB2 = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_in = 1'b0;
  logic [7:0] ad = HI;
  logic       sync_out;
  logic [7:0] da;
  logic       ferr;
  logic [7:0] errc;

  logic       rst2 = 1'b0;
  logic       sync2 = 1'b0;
  logic [7:0] ad2 = HI;
  logic       sync_out2;
  logic [7:0] da2;
  logic       ferr2;
  logic [7:0] errc2;

  receiver_core #(.SAMPLES_PER_BIT(SPB)) dut (
    .clock             (clk),
    .resetN            (rst_n),
    .receiver_sync_in  (sync_in),
    .receiver_ad       (ad),
    .receiver_sync_out (sync_out),
    .receiver_da       (da),
    .frame_err         (ferr),
    .err_count         (errc)
  );

  receiver_core #(.SAMPLES_PER_BIT(SPB2)) dut_sat (
    .clock             (clk),
    .resetN            (rst2),
    .receiver_sync_in  (sync2),
    .receiver_ad       (ad2),
    .receiver_sync_out (sync_out2),
    .receiver_da       (da2),
    .frame_err         (ferr2),
    .err_count         (errc2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         ok;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] m_da = 8'h00;
  logic [7:0] m_err = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         strobe_cyc[$];
  int         ferr_n = 0;
  int         ferr2_n = 0;
  int         strobe2_n = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected strobes/errors come from the frames the
  // driver sent; the model's byte and count move only on events.
  ev_t e;
  bit  e_ok;
  bit  e_err;
  always @(negedge clk) begin
    if (rst_n) begin
      e_ok  = 1'b0;
      e_err = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.ok) begin
          e_ok = 1'b1;
          m_da = e.b;
        end else begin
          e_err = 1'b1;
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end
      check("sync_out", 32'(sync_out), 32'(e_ok));
      check("frame_err", 32'(ferr), 32'(e_err));
      check("receiver_da", 32'(da), 32'(m_da));
      check("err_count", 32'(errc), 32'(m_err));
      if (sync_out) strobe_cyc.push_back(cyc);
      if (ferr) ferr_n++;
    end
    if (rst2) begin
      if (ferr2) ferr2_n++;
      if (sync_out2) strobe2_n++;
    end
  end

  task automatic idle(input int n);
    ad = HI;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // abort_k >= 0 drops sync_in at the start of that bit.
  task automatic send_frame(input logic [7:0] b,
                            input bit stop_ok,
                            input bit spikes,
                            input int abort_k);
    logic [9:0] bits;
    logic       v;
    bits = {stop_ok, b, 1'b0};
    if (abort_k < 0) evq.push_back('{cyc + LAT, stop_ok, b});
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < SPB; i++) begin
        v = bits[k];
        if (spikes && k >= 1 && k <= 8 && i == C) v = ~v;
        if (k == abort_k && i == 0) sync_in = 1'b0;
        ad = v ? HI : LO;
        @(posedge clk);
        #1;
      end
    end
    ad = HI;
  endtask

  task automatic main_seq;
    int t1;
    int n0;
    sync_in = 1'b1;
    idle(20);

    t1 = cyc;
    send_frame(8'h20, 1'b1, 1'b0, -1);
    idle(60);
    check("t1_da", 32'(da), 32'h20);
    check("t1_nstrobe", 32'(strobe_cyc.size()), 32'd1);
    if (strobe_cyc.size() > 0)
      check("t1_latency", 32'(strobe_cyc[0] - t1), 32'd687);
    check("t1_ferr_n", 32'(ferr_n), 32'd0);

    n0 = strobe_cyc.size();
    for (int b = 8'h20; b <= 8'h2F; b++)
      send_frame(8'(b), 1'b1, 1'b0, -1);
    idle(60);
    check("t2_nstrobe", 32'(strobe_cyc.size() - n0), 32'd16);
    for (int i = n0 + 1; i < strobe_cyc.size(); i++)
      check("t2_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd720);
    check("t2_da", 32'(da), 32'h2F);
    check("t2_err", 32'(errc), 32'd0);

    n0 = strobe_cyc.size();
    ad = LO;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    idle(100);
    check("t3_glitch_nstrobe", 32'(strobe_cyc.size()), 32'(n0));
    check("t3_glitch_ferr", 32'(ferr_n), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(60);
    check("t3_da", 32'(da), 32'hA5);

    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(30);
    check("t4_err", 32'(errc), 32'd1);
    check("t4_da_held", 32'(da), 32'hA5);
    check("t4_ferr_n", 32'(ferr_n), 32'd1);

    send_frame(8'h55, 1'b1, 1'b1, -1);
    idle(60);
    check("t5_da", 32'(da), 32'h55);

    n0 = strobe_cyc.size();
    send_frame(8'h77, 1'b1, 1'b0, 5);
    idle(60);
    sync_in = 1'b1;
    idle(60);
    check("t6_abort_nstrobe", 32'(strobe_cyc.size()), 32'(n0));
    check("t6_abort_da", 32'(da), 32'h55);
    check("t6_abort_err", 32'(errc), 32'd1);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    idle(60);
    check("t6_da", 32'(da), 32'h11);

    ad = LO;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    evq.delete();
    m_da = 8'h00;
    m_err = 8'h00;
    #1;
    check("rst_mid_da", 32'(da), 32'h00);
    check("rst_mid_err", 32'(errc), 32'h00);
    check("rst_mid_sync_out", 32'(sync_out), 32'd0);
    check("rst_mid_ferr", 32'(ferr), 32'd0);
    idle(5);
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic sat_seq;
    logic [9:0] bits;
    bits = {1'b0, 8'h3C, 1'b0};
    sync2 = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    for (int n = 1; n <= 300; n++) begin
      for (int k = 0; k < 10; k++) begin
        for (int i = 0; i < SPB2; i++) begin
          ad2 = bits[k] ? HI : LO;
          @(posedge clk);
          #1;
        end
      end
      ad2 = HI;
      repeat (SPB2) begin
        @(posedge clk);
        #1;
      end
      check("sat_err", 32'(errc2), (n > 255) ? 32'd255 : 32'(n));
    end
    check("sat_ferr_n", 32'(ferr2_n), 32'd300);
    check("sat_nstrobe", 32'(strobe2_n), 32'd0);
    check("sat_da", 32'(da2), 32'h00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_da", 32'(da), 32'h00);
    check("rst_err", 32'(errc), 32'h00);
    check("rst_sync_out", 32'(sync_out), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    rst_n = 1'b1;
    rst2 = 1'b1;
    fork
      main_seq();
      sat_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
